// File: rtl/tte_pkg.sv
// Shared types and helpers for the tile transpose engine: FSM state encoding,
// default geometry and the index-width helper used by the top and the tile banks.
package tte_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_LINE_WIDTH = 512;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int E              = DEF_LINE_WIDTH / DEF_DATA_WIDTH;

    // Bits needed to index n rows/columns; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tte_if.sv
// Stream bundle between the input FIFO read side, the engine and the output FIFO write side.
// A line moves on a side only in a cycle where that side's valid and ready are both high;
// the producer keeps valid and data steady until that handshake, and ready never waits on valid.
interface tte_if #(
    parameter int LINE_WIDTH = 512
);
    logic                  in_valid;
    logic [LINE_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [LINE_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/tte_tile_bank.sv
// One ExE tile buffer: rows are written whole, and any column is read back
// combinationally as a packed line (element i of the result = row i of the tile).
module tte_tile_bank
    import tte_pkg::*;
#(
    parameter int LINE_WIDTH = 512,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                               clk,
    input  logic                                               i_we,
    input  logic [idx_width(LINE_WIDTH / DATA_WIDTH)-1:0]      i_row_idx,
    input  logic [LINE_WIDTH-1:0]                              i_data,
    input  logic [idx_width(LINE_WIDTH / DATA_WIDTH)-1:0]      i_col_idx,
    output logic [LINE_WIDTH-1:0]                              o_col_line
);
    localparam int N_ELEM = LINE_WIDTH / DATA_WIDTH;

    logic [LINE_WIDTH-1:0] r_rows [N_ELEM];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_rows[i_row_idx] <= i_data;
        end
    end

    always_comb begin
        o_col_line = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            o_col_line[i*DATA_WIDTH +: DATA_WIDTH] = r_rows[i][i_col_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/tile_transpose_engine.sv
// Streaming ExE tile transposer with two ping-pong tile banks (fill one, drain the other).
// Optional stall counters are built when TTE_PERF_CNT_EN is defined.
module tile_transpose_engine
    import tte_pkg::*;
#(
    parameter int LINE_WIDTH = 512,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] ctx_length,
    tte_if.slave                 bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output state_t               dbg_state
`ifdef TTE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_in_cycles,
    output logic [CNT_WIDTH-1:0] stall_out_cycles
`endif
);
    localparam int N_ELEM = LINE_WIDTH / DATA_WIDTH;
    localparam int IDX_W  = idx_width(N_ELEM);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_WIDTH-1:0]  r_len;
    logic [CNT_WIDTH-1:0]  r_lines_in;
    logic [CNT_WIDTH-1:0]  r_lines_out;
    logic [1:0]            r_full;
    logic [1:0]            w_full_nxt;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [IDX_W-1:0]      r_row;
    logic [IDX_W-1:0]      r_col;
    logic                  r_err;

    logic                  w_start_acc;
    logic                  w_len_zero;
    logic                  w_len_bad;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_last_row;
    logic                  w_last_col;
    logic                  w_last_line;
    logic [1:0]            w_bank_we;
    logic [LINE_WIDTH-1:0] w_col_line [2];

    assign w_start_acc = start && (r_state == IDLE);
    assign w_len_zero  = (ctx_length == '0);
    // E is a power of two, so the low index bits are the remainder mod E.
    assign w_len_bad   = (ctx_length[IDX_W-1:0] != '0);

    assign bus.in_ready  = (r_state == RUN) && !r_full[r_wr_bank] && (r_lines_in < r_len);
    assign bus.out_valid = r_full[r_rd_bank];
    assign bus.out_data  = r_full[r_rd_bank] ? w_col_line[r_rd_bank] : '0;

    assign w_in_fire   = bus.in_valid && bus.in_ready;
    assign w_out_fire  = bus.out_valid && bus.out_ready;
    assign w_last_row  = (r_row == IDX_W'(N_ELEM - 1));
    assign w_last_col  = (r_col == IDX_W'(N_ELEM - 1));
    assign w_last_line = (r_lines_out == (r_len - CNT_WIDTH'(1)));

    assign w_bank_we[0] = w_in_fire && (r_wr_bank == 1'b0);
    assign w_bank_we[1] = w_in_fire && (r_wr_bank == 1'b1);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tte_tile_bank #(
            .LINE_WIDTH (LINE_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk        (clk),
            .i_we       (w_bank_we[b]),
            .i_row_idx  (r_row),
            .i_data     (bus.in_data),
            .i_col_idx  (r_col),
            .o_col_line (w_col_line[b])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (w_len_zero || w_len_bad) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_out_fire && w_last_line) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == RUN);
        done      = (r_state == DONE);
        err       = r_err;
        dbg_state = r_state;
    end

    // A bank is only filled while empty and only drained while full, so set and clear never collide.
    always_comb begin
        w_full_nxt = r_full;
        if (w_in_fire && w_last_row) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_out_fire && w_last_col) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
            r_len       <= reset ? '0 : ctx_length;
            r_lines_in  <= '0;
            r_lines_out <= '0;
            r_full      <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_in_fire) begin
                r_lines_in <= r_lines_in + CNT_WIDTH'(1);
                r_row      <= w_last_row ? '0 : r_row + IDX_W'(1);
                if (w_last_row) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_out_fire) begin
                r_lines_out <= r_lines_out + CNT_WIDTH'(1);
                r_col       <= w_last_col ? '0 : r_col + IDX_W'(1);
                if (w_last_col) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= w_len_bad;
        end
    end

`ifdef TTE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_in;
    logic [CNT_WIDTH-1:0] r_stall_out;

    always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
            r_stall_in  <= '0;
            r_stall_out <= '0;
        end else begin
            if ((r_state == RUN) && bus.in_valid && !bus.in_ready) begin
                r_stall_in <= r_stall_in + CNT_WIDTH'(1);
            end
            if (bus.out_valid && !bus.out_ready) begin
                r_stall_out <= r_stall_out + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_in_cycles  = r_stall_in;
    assign stall_out_cycles = r_stall_out;
`endif

endmodule

// File: tb/tb_tile_transpose_engine.sv
// Bench for tile_transpose_engine at 64-bit lines / 8-bit elements (8x8 tiles).
// Stall-counter checks are compiled in when TTE_PERF_CNT_EN is defined.
module tb_tile_transpose_engine;
  import tte_pkg::*;

  localparam int LW = 64;
  localparam int DW = 8;
  localparam int CW = 32;
  localparam int NE = LW / DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] ctx_length;
  logic          busy;
  logic          done;
  logic          err;
  state_t        dbg_state;
`ifdef TTE_PERF_CNT_EN
  logic [CW-1:0] stall_in_cycles;
  logic [CW-1:0] stall_out_cycles;
`endif

  tte_if #(.LINE_WIDTH(LW)) bus ();

  tile_transpose_engine #(
    .LINE_WIDTH (LW),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ctx_length (ctx_length),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
`ifdef TTE_PERF_CNT_EN
    ,
    .stall_in_cycles  (stall_in_cycles),
    .stall_out_cycles (stall_out_cycles)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_bad    = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- job bookkeeping (main flow writes, monitor reads) ----------------
  int job_id      = 0;
  int job_len     = 0;
  bit stream_mode = 1'b0;
  int or_mode     = 2;   // 0 random, 1 always ready, 2 manual

  // ---------------- scoreboard / monitor state ----------------
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] tile_buf [NE];
  logic [LW-1:0] prev_data;
  logic [LW-1:0] exp_line;
  logic [LW-1:0] line_tmp;
  bit prev_stall  = 1'b0;
  bit lat_pending = 1'b0;
  int seen_job    = 0;
  int acc_in      = 0;
  int out_seen    = 0;
  int occ         = 0;
  int full_hits   = 0;
  int in_drops    = 0;
  int ov_gaps     = 0;
  int done_cnt    = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      acc_in = 0; out_seen = 0; occ = 0;
      prev_stall = 1'b0; lat_pending = 1'b0;
    end else begin
      if (job_id != seen_job) begin
        seen_job = job_id;
        exp_q.delete();
        acc_in = 0; out_seen = 0; occ = 0; full_hits = 0;
        in_drops = 0; ov_gaps = 0;
        prev_stall = 1'b0; lat_pending = 1'b0;
      end
      if (prev_stall) begin
        chk("hold_valid", LW'(bus.out_valid), LW'(1));
        chk("hold_data", bus.out_data, prev_data);
      end
      if (occ == 2) begin
        full_hits++;
        chk("both_full_in_ready", LW'(bus.in_ready), LW'(0));
      end
      if (lat_pending) begin
        chk("lat_post", LW'(bus.out_valid), LW'(1));
        lat_pending = 1'b0;
      end
      if (stream_mode) begin
        if (acc_in >= NE && acc_in < job_len && !bus.in_ready) in_drops++;
        if (out_seen > 0 && out_seen < job_len && !bus.out_valid) ov_gaps++;
      end
      if (done) done_cnt++;
      if (bus.in_valid && bus.in_ready) begin
        tile_buf[acc_in % NE] = bus.in_data;
        if ((acc_in % NE) == NE - 1) begin
          if (acc_in == NE - 1) begin
            chk("lat_pre", LW'(bus.out_valid), LW'(0));
            lat_pending = 1'b1;
          end
          for (int j = 0; j < NE; j++) begin
            line_tmp = '0;
            for (int i = 0; i < NE; i++) line_tmp[i*DW +: DW] = tile_buf[i][j*DW +: DW];
            exp_q.push_back(line_tmp);
          end
          occ++;
        end
        acc_in++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_line", bus.out_data, '0);
        end else begin
          exp_line = exp_q.pop_front();
          chk("sb_data", bus.out_data, exp_line);
        end
        out_seen++;
        if (out_seen % NE == 0) occ--;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  // ---------------- out_ready driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (or_mode == 1)      bus.out_ready = 1'b1;
      else if (or_mode == 0) bus.out_ready = ($urandom_range(0, 2) == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  function automatic logic [LW-1:0] make_line(input int g);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < NE; i++) l[i*DW +: DW] = DW'(g * NE + i);
    return l;
  endfunction

  task automatic begin_job(input int len, input bit stream);
    job_len     = len;
    stream_mode = stream;
    job_id++;
  endtask

  task automatic pulse_start(input int len);
    start = 1'b1;
    ctx_length = CW'(len);
    sync();
    start = 1'b0;
  endtask

  task automatic drive_lines(input int n, input bit gaps);
    int g = 0;
    int guard = 0;
    bit fire;
    while (g < n && guard < 2000) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = make_line(g);
      end
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      sync();
      if (fire) g++;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (guard >= 2000) chk("drive_timeout", LW'(g), LW'(n));
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      sync();
      k++;
    end
    if (done_cnt == d0) chk("done_timeout", LW'(0), LW'(1));
  endtask

  task automatic run_job(input int len, input bit gaps, input int rmode, input bit stream);
    int d0;
    or_mode = rmode;
    begin_job(len, stream);
    d0 = done_cnt;
    pulse_start(len);
    drive_lines(len, gaps);
    wait_done(d0, 1000);
    repeat (3) sync();
    chk("lines_out", LW'(out_seen), LW'(len));
    chk("done_once", LW'(done_cnt - d0), LW'(1));
    chk("sb_drained", LW'(exp_q.size()), LW'(0));
    chk("err_clear", LW'(err), LW'(0));
  endtask

  task automatic check_quiet(input string tag);
    chk(tag, {58'd0, bus.in_ready, bus.out_valid, busy, done, err, |bus.out_data}, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; ctx_length = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) sync();
    @(negedge clk);
    check_quiet("reset_outputs");
    chk("reset_state", LW'(dbg_state), LW'(IDLE));
    sync();
    reset = 1'b0;
    sync();

    // single tile, out_ready high
    run_job(8, 1'b0, 1, 1'b0);

    // streaming, both sides always ready
    run_job(32, 1'b0, 1, 1'b1);
    chk("stream_in_ready_drops", LW'(in_drops), LW'(0));
    chk("stream_out_valid_gaps", LW'(ov_gaps), LW'(0));

    // back-pressure with random out_ready
    run_job(16, 1'b0, 0, 1'b0);
    chk("bp_both_full_seen", LW'(full_hits > 0), LW'(1));
    run_job(16, 1'b1, 0, 1'b0);

    // length not a multiple of E
    or_mode = 1;
    begin_job(12, 1'b0);
    pulse_start(12);
    @(negedge clk);
    chk("len12_done", LW'(done), LW'(1));
    chk("len12_err", LW'(err), LW'(1));
    chk("len12_in_ready", LW'(bus.in_ready), LW'(0));
    sync();
    @(negedge clk);
    chk("len12_done_pulse", LW'(done), LW'(0));
    chk("len12_err_sticky", LW'(err), LW'(1));
    sync();

    // zero length
    begin_job(0, 1'b0);
    pulse_start(0);
    @(negedge clk);
    chk("len0_done", LW'(done), LW'(1));
    chk("len0_err", LW'(err), LW'(0));
    sync();

    // reset in the middle of a job
    begin_job(16, 1'b0);
    pulse_start(16);
    drive_lines(5, 1'b0);
    reset = 1'b1;
    sync();
    @(negedge clk);
    check_quiet("midjob_reset_outputs");
    chk("midjob_reset_state", LW'(dbg_state), LW'(IDLE));
    sync();
    reset = 1'b0;
    sync();
    run_job(8, 1'b0, 1, 1'b0);

`ifdef TTE_PERF_CNT_EN
    begin
      int d0;
      or_mode = 2;
      bus.out_ready = 1'b0;
      begin_job(8, 1'b0);
      d0 = done_cnt;
      pulse_start(8);
      drive_lines(8, 1'b0);
      repeat (10) sync();
      bus.out_ready = 1'b1;
      wait_done(d0, 200);
      chk("perf_stall_out", LW'(stall_out_cycles), LW'(10));
      chk("perf_stall_in", LW'(stall_in_cycles), LW'(0));
      chk("perf_lines_out", LW'(out_seen), LW'(8));
    end
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
